seq_fp_mul: RTL and testbench
=============================

SEQ_FP_MUL -- requirements
Module: seq_fp_mul

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 SHALL have port a, input, 32 bits: IEEE-754 single-precision multiplicand, sampled with start.
REQ-005 SHALL have port b, input, 32 bits: IEEE-754 single-precision multiplier, sampled with start.
REQ-006 SHALL have port m, output, 32 bits: registered product.
REQ-007 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse; m and flags valid.
REQ-009 SHALL have port overflow, output, 1 bit: result exponent exceeded 254.
REQ-010 SHALL have port underflow, output, 1 bit: result exponent below 1.

Function
REQ-011 SHALL implement FSM states IDLE, SPECIAL, MUL, NORM, DONE.
REQ-012 IDLE with start=1 SHALL register a and b, then classify both operands in the same cycle.
- Zero: exponent 0, any fraction; denormals are treated as zero.
- Inf: exponent 255, fraction 0.
- NaN: exponent 255, fraction nonzero.
- Any special class -> SPECIAL; otherwise -> MUL.
REQ-013 start while not in IDLE SHALL be ignored with no effect on the operation in progress.
REQ-014 Sign SHALL be a[31] XOR b[31] for every result except NaN.
REQ-015 SPECIAL SHALL select the result in this priority order, clear both flags, and go to DONE after one cycle.
- NaN operand, or zero times inf: 32'h7FC00000.
- Inf operand: {sign, 8'hFF, 23'h0}.
- Zero operand: {sign, 31'h0}.
REQ-016 MUL SHALL form the 48-bit product of {1,a[22:0]} and {1,b[22:0]} by shift-add, one multiplier bit per cycle, for exactly 24 cycles.
REQ-017 The exponent SHALL be computed in 10-bit signed arithmetic as ea + eb - 127.
REQ-018 NORM SHALL take one cycle and normalise the product.
- p[47]=1: fraction = p[46:24], exponent + 1.
- p[47]=0: fraction = p[45:23].
- Rounding is truncation (toward zero).
REQ-019 After normalisation, exponent >= 255 SHALL give m = {sign, 8'hFF, 23'h0}, overflow=1, underflow=0.
REQ-020 After normalisation, exponent <= 0 SHALL give m = {sign, 31'h0}, underflow=1, overflow=0.
REQ-021 Otherwise m SHALL be {sign, exponent[7:0], fraction}, with both flags cleared.
REQ-022 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; m and the flags hold their values until the next completed operation.
REQ-023 busy SHALL be 1 in SPECIAL, MUL, NORM and DONE, and 0 in IDLE.
REQ-024 Latency, with start sampled at edge 0:
- Normal operands: done high in cycle 26.
- Special operands: done high in cycle 2.
REQ-025 A new start SHALL be accepted in the cycle after done (back-to-back operation).
REQ-026 All outputs SHALL be deterministic; no X is ever driven.

Reset
REQ-027 rst_n=0 SHALL immediately force the following, asynchronously, in any state including mid-MUL:
- FSM to IDLE.
- m=0, busy=0, done=0, overflow=0, underflow=0.
- Internal product, counter and operand registers cleared.
REQ-028 After rst_n rises, the first start SHALL be honoured on the next clock edge.

Verification
REQ-029 a=40000000, b=40400000 (2.0 x 3.0) -> m=40C00000 in cycle 26, flags 0, busy high in cycles 1-26.
REQ-030 a=3FC00000, b=3FC00000 (1.5 x 1.5) -> m=40100000, normalisation path p[47]=1 taken.
REQ-031 a=7F000000, b=7F000000 -> m=7F800000, overflow=1; then a=00800000, b=00800000 -> m=00000000, underflow=1.
REQ-032 a=00000000, b=FF800000 (0 x -inf) -> m=7FC00000 with done in cycle 2; a=80000000, b=3F800000 -> m=80000000.
REQ-033 start pulsed with different operands in cycles 5 and 26 of an operation -> both ignored, original result delivered; start in cycle 27 is accepted.
REQ-034 rst_n pulsed low in cycle 10 of an operation -> all outputs 0 asynchronously, no done pulse; a fresh 2.0 x 3.0 after release -> 40C00000 after 26 cycles.

Source files
------------

// File: rtl/seq_fp_mul.sv
// seq_fp_mul -- sequential IEEE-754 single-precision multiplier.
// Mantissas are multiplied by shift-add, one multiplier bit per clock
// (24 cycles), then normalised in one cycle with truncation rounding.
// Denormal inputs are treated as zero. Zero/Inf/NaN take a short path.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request a multiply (sampled only when idle)
//   a, b      in   [31:0] operands, sampled with start
//   m         out  [31:0] registered product
//   busy      out  operation in progress
//   done      out  one-cycle pulse, m and flags valid
//   overflow  out  result exponent exceeded 254
//   underflow out  result exponent below 1
module seq_fp_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] m,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [2:0] {IDLE, SPECIAL, MUL, NORM, DONE} state_t;

    state_t       state, state_nx;
    logic [31:0]  a_r, b_r;
    logic [47:0]  prod;
    logic [47:0]  mcand;     // multiplicand, shifted left each MUL cycle
    logic [23:0]  mplier;    // multiplier, shifted right each MUL cycle
    logic [4:0]   cnt;

    // Exponent 0 (zero/denormal) or 255 (inf/NaN) sends an operand down
    // the special path; evaluated on the live inputs so the decision is
    // made in the same cycle start is accepted.
    logic in_special;
    assign in_special = (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
                        (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);

    logic sign;
    assign sign = a_r[31] ^ b_r[31];

    // Special-case result from the registered operands
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [31:0] spec_res;
    assign a_zero = (a_r[30:23] == 8'h00);
    assign b_zero = (b_r[30:23] == 8'h00);
    assign a_inf  = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
    assign b_inf  = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
    assign a_nan  = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
    assign b_nan  = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);

    always_comb begin
        if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero))
            spec_res = 32'h7FC0_0000;
        else if (a_inf || b_inf)
            spec_res = {sign, 8'hFF, 23'd0};
        else
            spec_res = {sign, 31'd0};
    end

    // Normalisation: signed 10-bit exponent so both overflow (>=255) and
    // underflow (<=0) are visible without wrap.
    logic signed [9:0] exp_n;
    logic [22:0]       frac_n;
    assign exp_n = $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]})
                 - 10'sd127 + $signed({9'd0, prod[47]});
    assign frac_n = prod[47] ? prod[46:24] : prod[45:23];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = in_special ? SPECIAL : MUL;
            SPECIAL: state_nx = DONE;
            MUL:     if (cnt == 5'd23) state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            prod      <= 48'd0;
            mcand     <= 48'd0;
            mplier    <= 24'd0;
            cnt       <= 5'd0;
            m         <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r    <= a;
                    b_r    <= b;
                    prod   <= 48'd0;
                    mcand  <= {24'd0, 1'b1, a[22:0]};
                    mplier <= {1'b1, b[22:0]};
                    cnt    <= 5'd0;
                end
                SPECIAL: begin
                    m         <= spec_res;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                end
                NORM: begin
                    if (exp_n >= 10'sd255) begin
                        m         <= {sign, 8'hFF, 23'd0};
                        overflow  <= 1'b1;
                        underflow <= 1'b0;
                    end else if (exp_n <= 10'sd0) begin
                        m         <= {sign, 31'd0};
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                    end else begin
                        m         <= {sign, exp_n[7:0], frac_n};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fp_mul.sv
// Directed testbench for seq_fp_mul: reset, normal products, normalisation
// paths, truncation, overflow/underflow, special operands, ignored start,
// back-to-back operation and mid-operation reset.
module tb_seq_fp_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] m;
    logic        busy, done, overflow, underflow;

    int errors = 0;
    int checks = 0;

    seq_fp_mul dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .m(m), .busy(busy), .done(done),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Launch one operation (start sampled at edge 0) and wait for done.
    // lat is the cycle number in which done was seen, -1 on timeout.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] rm, output logic rov,
                          output logic run, output int lat,
                          output logic bsy_ok);
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; bsy_ok = 1'b1;
        rm = 32'hDEAD_BEEF; rov = 1'bx; run = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) bsy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = k; rm = m; rov = overflow; run = underflow;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m, busy, done, overflow, underflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got m=%h busy=%b done=%b ov=%b un=%b want all 0",
                     m, busy, done, overflow, underflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] rm; logic rov, run, bok; int lat;
        run_op(32'h4000_0000, 32'h4040_0000, rm, rov, run, lat, bok);
        checks++;
        if (rm !== 32'h40C0_0000) begin errors++; $display("FAIL mul_2x3: got %h want 40c00000", rm); end
        checks++;
        if (lat != 26) begin errors++; $display("FAIL lat_2x3: got %0d want 26", lat); end
        checks++;
        if ({rov, run} !== 2'b00) begin errors++; $display("FAIL flags_2x3: got %b%b want 00", rov, run); end
        checks++;
        if (bok !== 1'b1) begin errors++; $display("FAIL busy_2x3: busy dropped during cycles 1-26"); end
        // done is a single pulse; m holds afterwards
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (m !== 32'h40C0_0000) begin errors++; $display("FAIL m_hold: got %h want 40c00000", m); end
    endtask

    task automatic test_normalise;
        logic [31:0] rm; logic rov, run, bok; int lat;
        run_op(32'h3FC0_0000, 32'h3FC0_0000, rm, rov, run, lat, bok);
        checks++;
        if (rm !== 32'h4010_0000) begin errors++; $display("FAIL mul_1p5sq: got %h want 40100000", rm); end
        // mantissa (2^24-1)^2 -> truncated fraction 7FFFFE
        run_op(32'h3FFF_FFFF, 32'h3FFF_FFFF, rm, rov, run, lat, bok);
        checks++;
        if (rm !== 32'h407F_FFFE) begin errors++; $display("FAIL truncate: got %h want 407ffffe", rm); end
        run_op(32'h3F80_0000, 32'hC000_0000, rm, rov, run, lat, bok);
        checks++;
        if (rm !== 32'hC000_0000) begin errors++; $display("FAIL neg_sign: got %h want c0000000", rm); end
    endtask

    task automatic test_range;
        logic [31:0] rm; logic rov, run, bok; int lat;
        run_op(32'h7F00_0000, 32'h7F00_0000, rm, rov, run, lat, bok);
        checks++;
        if ({rm, rov, run} !== {32'h7F80_0000, 2'b10}) begin
            errors++; $display("FAIL overflow: got m=%h ov=%b un=%b want 7f800000 1 0", rm, rov, run);
        end
        run_op(32'h0080_0000, 32'h0080_0000, rm, rov, run, lat, bok);
        checks++;
        if ({rm, rov, run} !== {32'h0000_0000, 2'b01}) begin
            errors++; $display("FAIL underflow: got m=%h ov=%b un=%b want 00000000 0 1", rm, rov, run);
        end
    endtask

    task automatic test_special;
        logic [31:0] rm; logic rov, run, bok; int lat;
        // underflow flag is still set from the previous op: must clear
        run_op(32'h0000_0000, 32'hFF80_0000, rm, rov, run, lat, bok);
        checks++;
        if ({rm, rov, run} !== {32'h7FC0_0000, 2'b00}) begin
            errors++; $display("FAIL zero_x_inf: got m=%h ov=%b un=%b want 7fc00000 0 0", rm, rov, run);
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL lat_special: got %0d want 2", lat); end
        run_op(32'h8000_0000, 32'h3F80_0000, rm, rov, run, lat, bok);
        checks++;
        if (rm !== 32'h8000_0000) begin errors++; $display("FAIL neg_zero: got %h want 80000000", rm); end
        run_op(32'h7F80_0000, 32'hC000_0000, rm, rov, run, lat, bok);
        checks++;
        if (rm !== 32'hFF80_0000) begin errors++; $display("FAIL inf_x_neg2: got %h want ff800000", rm); end
        run_op(32'h3F80_0000, 32'hFFC0_0001, rm, rov, run, lat, bok);
        checks++;
        if (rm !== 32'h7FC0_0000) begin errors++; $display("FAIL nan_in: got %h want 7fc00000", rm); end
        run_op(32'h0000_0001, 32'h3F80_0000, rm, rov, run, lat, bok);
        checks++;
        if ({rm, lat} !== {32'h0000_0000, 32'd2}) begin
            errors++; $display("FAIL denormal: got m=%h lat=%0d want 00000000 2", rm, lat);
        end
    endtask

    task automatic test_ignore_start;
        logic [31:0] rm; logic rov, run, bok; int lat;
        @(negedge clk);
        a = 32'h4000_0000; b = 32'h4040_0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; rm = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5 || k == 26) begin
                a = 32'h3F80_0000; b = 32'h3F80_0000; start = 1'b1;
            end
            if (done === 1'b1 && lat < 0) begin lat = k; rm = m; end
            @(posedge clk);
            #1 start = 1'b0;
            if (lat > 0) break;
        end
        checks++;
        if ({rm, lat} !== {32'h40C0_0000, 32'd26}) begin
            errors++; $display("FAIL ignore_start: got m=%h lat=%0d want 40c00000 26", rm, lat);
        end
        // start in cycle 27 accepted (back-to-back)
        run_op(32'h3FC0_0000, 32'h3FC0_0000, rm, rov, run, lat, bok);
        checks++;
        if ({rm, lat} !== {32'h4010_0000, 32'd26}) begin
            errors++; $display("FAIL back_to_back: got m=%h lat=%0d want 40100000 26", rm, lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rm; logic rov, run, bok; int lat;
        logic saw_done;
        @(negedge clk);
        a = 32'h4000_0000; b = 32'h4040_0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m, busy, done, overflow, underflow} !== 36'd0) begin
            errors++;
            $display("FAIL reset_async: got m=%h busy=%b done=%b ov=%b un=%b want all 0",
                     m, busy, done, overflow, underflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL reset_abort: got activity after reset want none"); end
        run_op(32'h4000_0000, 32'h4040_0000, rm, rov, run, lat, bok);
        checks++;
        if ({rm, lat} !== {32'h40C0_0000, 32'd26}) begin
            errors++; $display("FAIL after_reset: got m=%h lat=%0d want 40c00000 26", rm, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_normalise();
        test_range();
        test_special();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
